// File: rtl/md_issue_ctrl.sv
// Issue/hazard controller for the HI/LO multiply-divide unit: issues E-stage MD ops and stalls D while the unit is occupied.
// Optional stall-cycle counter is built only when MD_ISSUE_PERF_EN is defined.
module md_issue_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  e_op,
  input  logic        e_valid,
  input  logic        e_flush,
  input  logic        d_md_use,
  output logic        md_start,
  output logic [2:0]  md_sel,
  output logic        md_busy,
  output logic        stall,
  output logic        proto_err,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, MBUSY, DBUSY} state_e;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             proto_err_q, proto_err_d;
  logic             op_mul, op_div, op_mt, op_any, issue;

  always_comb begin
    op_mul = (e_op == 3'd1) || (e_op == 3'd2);
    op_div = (e_op == 3'd3) || (e_op == 3'd4);
    op_mt  = (e_op == 3'd5) || (e_op == 3'd6);
    op_any = op_mul || op_div || op_mt;
    issue  = e_valid && !e_flush && (state_q == IDLE) && op_any;

    state_d     = state_q;
    cnt_d       = cnt_q;
    // Any real E op reaching us while occupied means the stall was bypassed.
    proto_err_d = proto_err_q || (e_valid && op_any && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (issue && op_mul) begin
          state_d = MBUSY;
          cnt_d   = MULT_LOAD;
        end else if (issue && op_div) begin
          state_d = DBUSY;
          cnt_d   = DIV_LOAD;
        end
      end
      default: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign md_start  = !reset && issue && (op_mul || op_div);
  assign md_sel    = (!reset && issue) ? e_op : 3'd0;
  assign md_busy   = !reset && (state_q != IDLE);
  // mthi/mtlo complete at the issue edge, so only mult/div issue adds a hazard.
  assign stall     = d_md_use && (md_busy || md_start);
  assign proto_err = proto_err_q;

`ifdef MD_ISSUE_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed vector bench for md_issue_ctrl: table of per-cycle stimulus/expectations plus
// hand sequences for the full divide window and reset during an operation.
module tb_md_issue_ctrl;

  logic        clk;
  logic        reset;
  logic [2:0]  e_op;
  logic        e_valid;
  logic        e_flush;
  logic        d_md_use;
  logic        md_start;
  logic [2:0]  md_sel;
  logic        md_busy;
  logic        stall;
  logic        proto_err;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

`ifdef MD_ISSUE_PERF_EN
  localparam int DIV_STALL_CNT = 11;
`else
  localparam int DIV_STALL_CNT = 0;
`endif

  md_issue_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .e_op     (e_op),
    .e_valid  (e_valid),
    .e_flush  (e_flush),
    .d_md_use (d_md_use),
    .md_start (md_start),
    .md_sel   (md_sel),
    .md_busy  (md_busy),
    .stall    (stall),
    .proto_err(proto_err),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] op;
    logic       v;
    logic       f;
    logic       u;
    logic       x_start;
    logic [2:0] x_sel;
    logic       x_busy;
    logic       x_stall;
    logic       x_perr;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [2:0] op, input logic v, input logic f, input logic u);
    reset = rst; e_op = op; e_valid = v; e_flush = f; d_md_use = u;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nbusy;
    int nstall;

    //         rst op  v  f  u   start sel busy stall perr
    vecs[0]  = '{1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1};

    drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].v, vecs[i].f, vecs[i].u);
      @(negedge clk);
      chk($sformatf("vec%0d md_start", i), 32'(md_start), 32'(vecs[i].x_start));
      chk($sformatf("vec%0d md_sel", i), 32'(md_sel), 32'(vecs[i].x_sel));
      chk($sformatf("vec%0d md_busy", i), 32'(md_busy), 32'(vecs[i].x_busy));
      chk($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].x_stall));
      chk($sformatf("vec%0d proto_err", i), 32'(proto_err), 32'(vecs[i].x_perr));
      next_cycle();
    end

    // Full divide window with d_md_use held and a flush arriving mid-operation.
    drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("post-reset proto_err", 32'(proto_err), 32'd0);
    chk("post-reset stall_cnt", stall_cnt, 32'd0);
    next_cycle();

    drive(1'b0, 3'd4, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("div issue md_start", 32'(md_start), 32'd1);
    chk("div issue md_sel", 32'(md_sel), 32'd4);
    nbusy  = 0;
    nstall = stall ? 1 : 0;
    next_cycle();
    for (int c = 1; c <= 14; c++) begin
      drive(1'b0, 3'd0, 1'b0, (c == 2), 1'b1);
      @(negedge clk);
      if (md_busy) nbusy++;
      if (stall) nstall++;
      if (c == 10) chk("div last busy cycle", 32'(md_busy), 32'd1);
      if (c == 11) chk("div idle after window", 32'(md_busy), 32'd0);
      next_cycle();
    end
    chk("div busy cycles", 32'(nbusy), 32'd10);
    chk("div stall cycles", 32'(nstall), 32'd11);
    chk("div stall_cnt", stall_cnt, 32'(DIV_STALL_CNT));

    // Reset landing in cycle 3 of a divide, with proto_err set beforehand.
    drive(1'b0, 3'd3, 1'b1, 1'b0, 1'b1);
    next_cycle();
    drive(1'b0, 3'd1, 1'b1, 1'b0, 1'b1);
    next_cycle();
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("rst-seq proto_err set", 32'(proto_err), 32'd1);
    chk("rst-seq busy before reset", 32'(md_busy), 32'd1);
    next_cycle();
    drive(1'b1, 3'd1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("reset cycle md_busy", 32'(md_busy), 32'd0);
    chk("reset cycle stall", 32'(stall), 32'd0);
    chk("reset cycle md_start", 32'(md_start), 32'd0);
    chk("reset cycle md_sel", 32'(md_sel), 32'd0);
    next_cycle();
    drive(1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("after reset md_busy", 32'(md_busy), 32'd0);
    chk("after reset stall", 32'(stall), 32'd0);
    chk("after reset proto_err", 32'(proto_err), 32'd0);
    chk("after reset stall_cnt", stall_cnt, 32'd0);
    chk("after reset reissue md_start", 32'(md_start), 32'd1);
    chk("after reset reissue md_sel", 32'(md_sel), 32'd1);
    next_cycle();
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("reissue busy", 32'(md_busy), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
